// File: rtl/zba_zbc_zbs_sirali.sv
// Sequential Zba/Zbc/Zbs bit-manipulation unit with a valid/ready handshake on both sides.
// Latency: Zba/Zbs/other ops 1 cycle; Zbc VERI_W/ADIM+1 cycles from acceptance to gecerli_o.
// Backpressure: one operation in flight; hazir_o only in BOSTA, result held in SONUC until hazir_i.

package zba_zbc_zbs_sirali_pkg;

  typedef enum logic [3:0] {
    ISLEM_YOK  = 4'd0,
    ZBA_SH1ADD = 4'd1,
    ZBA_SH2ADD = 4'd2,
    ZBA_SH3ADD = 4'd3,
    ZBS_BCLR   = 4'd4,
    ZBS_BSET   = 4'd5,
    ZBS_BINV   = 4'd6,
    ZBS_BEXT   = 4'd7,
    ZBC_CLMUL  = 4'd8,
    ZBC_CLMULH = 4'd9,
    ZBC_CLMULR = 4'd10
  } amb_islem_t;

endpackage

module zba_zbc_zbs_sirali
  import zba_zbc_zbs_sirali_pkg::*;
#(
  parameter int VERI_W = 32,
  parameter int ADIM   = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              gecerli_i,
  output logic              hazir_o,
  input  amb_islem_t        islem_i,
  input  logic [VERI_W-1:0] veri1_i,
  input  logic [VERI_W-1:0] veri2_i,
  input  logic              iptal_i,
  output logic              gecerli_o,
  input  logic              hazir_i,
  output logic [VERI_W-1:0] sonuc_o
);

  localparam int SAYI  = VERI_W / ADIM;
  localparam int SAY_W = $clog2(SAYI) + 1;
  localparam int IDX_W = $clog2(VERI_W);

  typedef enum logic [1:0] {
    BOSTA   = 2'd0,
    HESAPLA = 2'd1,
    SONUC   = 2'd2
  } durum_t;

  durum_t                durum_q, durum_d;
  amb_islem_t            islem_q, islem_d;
  // Multiplicand pre-shifted left by the bits already consumed, so no variable shifter is needed.
  logic [2*VERI_W-1:0]   carpan_q, carpan_d;
  // Multiplier shifted right each cycle; its low ADIM bits are the current chunk.
  logic [VERI_W-1:0]     veri2_q, veri2_d;
  logic [2*VERI_W-1:0]   acc_q, acc_d;
  logic [SAY_W-1:0]      sayac_q, sayac_d;
  logic [VERI_W-1:0]     sonuc_q, sonuc_d;

  logic [VERI_W-1:0]     tek_sonuc;
  logic [2*VERI_W-1:0]   acc_sonraki;
  logic [VERI_W-1:0]     zbc_sonuc;
  logic                  zbc_mi;
  logic [IDX_W-1:0]      bit_idx;
  logic [VERI_W-1:0]     bit_maske;

  // Single-cycle Zba/Zbs result straight from the request operands.
  always_comb begin
    tek_sonuc = '0;
    bit_idx   = veri2_i[IDX_W-1:0];
    bit_maske = {{(VERI_W-1){1'b0}}, 1'b1} << bit_idx;
    zbc_mi    = (islem_i == ZBC_CLMUL) || (islem_i == ZBC_CLMULH) || (islem_i == ZBC_CLMULR);
    case (islem_i)
      ZBA_SH1ADD: tek_sonuc = veri2_i + (veri1_i << 1);
      ZBA_SH2ADD: tek_sonuc = veri2_i + (veri1_i << 2);
      ZBA_SH3ADD: tek_sonuc = veri2_i + (veri1_i << 3);
      ZBS_BCLR:   tek_sonuc = veri1_i & ~bit_maske;
      ZBS_BSET:   tek_sonuc = veri1_i | bit_maske;
      ZBS_BINV:   tek_sonuc = veri1_i ^ bit_maske;
      ZBS_BEXT:   tek_sonuc[0] = veri1_i[bit_idx];
      default:    tek_sonuc = '0;
    endcase
  end

  // One carry-less step: fold in veri1 << k for each set multiplier bit of this chunk.
  always_comb begin
    acc_sonraki = acc_q;
    for (int j = 0; j < ADIM; j++) begin
      if (veri2_q[j]) begin
        acc_sonraki = acc_sonraki ^ (carpan_q << j);
      end
    end
  end

  // Pick the requested half of the finished product; CLMULR is the window one bit below CLMULH.
  always_comb begin
    zbc_sonuc = '0;
    case (islem_q)
      ZBC_CLMUL:  zbc_sonuc = acc_sonraki[VERI_W-1:0];
      ZBC_CLMULH: zbc_sonuc = acc_sonraki[2*VERI_W-1:VERI_W];
      ZBC_CLMULR: zbc_sonuc = acc_sonraki[2*VERI_W-2:VERI_W-1];
      default:    zbc_sonuc = '0;
    endcase
  end

  // Next-state, datapath updates and handshake outputs; flush overrides everything.
  always_comb begin
    durum_d   = durum_q;
    islem_d   = islem_q;
    carpan_d  = carpan_q;
    veri2_d   = veri2_q;
    acc_d     = acc_q;
    sayac_d   = sayac_q;
    sonuc_d   = sonuc_q;
    hazir_o   = 1'b0;
    gecerli_o = 1'b0;
    sonuc_o   = '0;

    case (durum_q)
      BOSTA: begin
        hazir_o = 1'b1;
        if (gecerli_i) begin
          islem_d  = islem_i;
          carpan_d = {{VERI_W{1'b0}}, veri1_i};
          veri2_d  = veri2_i;
          acc_d    = '0;
          sayac_d  = '0;
          if (zbc_mi) begin
            durum_d = HESAPLA;
          end else begin
            sonuc_d = tek_sonuc;
            durum_d = SONUC;
          end
        end
      end
      HESAPLA: begin
        acc_d    = acc_sonraki;
        carpan_d = carpan_q << ADIM;
        veri2_d  = veri2_q >> ADIM;
        sayac_d  = sayac_q + 1'b1;
        if (sayac_q == SAY_W'(SAYI - 1)) begin
          sonuc_d = zbc_sonuc;
          durum_d = SONUC;
        end
      end
      SONUC: begin
        gecerli_o = 1'b1;
        sonuc_o   = sonuc_q;
        if (hazir_i) begin
          durum_d = BOSTA;
        end
      end
      default: begin
        durum_d = BOSTA;
      end
    endcase

    if (iptal_i) begin
      durum_d = BOSTA;
      acc_d   = '0;
      sayac_d = '0;
    end
  end

  // State and datapath registers; reset aborts any operation without waiting for an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      durum_q  <= BOSTA;
      islem_q  <= ISLEM_YOK;
      carpan_q <= '0;
      veri2_q  <= '0;
      acc_q    <= '0;
      sayac_q  <= '0;
      sonuc_q  <= '0;
    end else begin
      durum_q  <= durum_d;
      islem_q  <= islem_d;
      carpan_q <= carpan_d;
      veri2_q  <= veri2_d;
      acc_q    <= acc_d;
      sayac_q  <= sayac_d;
      sonuc_q  <= sonuc_d;
    end
  end

endmodule

// File: tb/tb_zba_zbc_zbs_sirali.sv
// Bench for zba_zbc_zbs_sirali: three instances (32/1, 32/4, 64/8) driven from shared operands.
// Latency is counted in edges from the accepting edge (1 = valid right after acceptance).
// Table of directed vectors followed by hand-written backpressure, flush and reset sequences.

module tb_zba_zbc_zbs_sirali;
  import zba_zbc_zbs_sirali_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iptal = 1'b0;
  logic        hazir_i = 1'b1;
  logic [2:0]  vld = 3'b000;
  logic [2:0]  hz;
  logic [2:0]  gv;
  amb_islem_t  islem = ISLEM_YOK;
  logic [63:0] v1 = '0;
  logic [63:0] v2 = '0;
  logic [31:0] s0, s1;
  logic [63:0] s2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  zba_zbc_zbs_sirali #(.VERI_W(32), .ADIM(1)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .gecerli_i(vld[0]), .hazir_o(hz[0]), .islem_i(islem),
    .veri1_i(v1[31:0]), .veri2_i(v2[31:0]), .iptal_i(iptal), .gecerli_o(gv[0]),
    .hazir_i(hazir_i), .sonuc_o(s0));

  zba_zbc_zbs_sirali #(.VERI_W(32), .ADIM(4)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .gecerli_i(vld[1]), .hazir_o(hz[1]), .islem_i(islem),
    .veri1_i(v1[31:0]), .veri2_i(v2[31:0]), .iptal_i(iptal), .gecerli_o(gv[1]),
    .hazir_i(hazir_i), .sonuc_o(s1));

  zba_zbc_zbs_sirali #(.VERI_W(64), .ADIM(8)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .gecerli_i(vld[2]), .hazir_o(hz[2]), .islem_i(islem),
    .veri1_i(v1), .veri2_i(v2), .iptal_i(iptal), .gecerli_o(gv[2]),
    .hazir_i(hazir_i), .sonuc_o(s2));

  typedef struct {
    int          u;
    amb_islem_t  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
    string       nm;
  } vek_t;

  vek_t tablo[$];

  function automatic logic [63:0] son(input int u);
    case (u)
      0:       return {32'h0, s0};
      1:       return {32'h0, s1};
      default: return s2;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Issue one request on instance u, measure latency, check result, then let it drain.
  task automatic run_op(input int u, input amb_islem_t op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int exp_lat,
                        input string nm);
    int lat;
    @(negedge clk);
    islem = op; v1 = a; v2 = b; vld[u] = 1'b1;
    chk({nm, " hazir_o"}, {63'h0, hz[u]}, 64'h1);
    @(posedge clk);
    #1;
    vld[u] = 1'b0;
    islem = ISLEM_YOK; v1 = '1; v2 = '1;
    lat = 1;
    while (!gv[u] && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, " result"}, son(u), exp);
    @(posedge clk);
    #1;
    chk({nm, " drained"}, {63'h0, gv[u]}, 64'h0);
  endtask

  initial begin
    int cnt;

    tablo.push_back('{0, ZBC_CLMUL,  64'h3, 64'h3, 64'h5, 33, "clmul 3x3 w32a1"});
    tablo.push_back('{0, ZBC_CLMULH, 64'h80000000, 64'h80000000, 64'h40000000, 33, "clmulh w32a1"});
    tablo.push_back('{0, ZBC_CLMULR, 64'h80000000, 64'h80000000, 64'h80000000, 33, "clmulr w32a1"});
    tablo.push_back('{1, ZBC_CLMULH, 64'h80000000, 64'h80000000, 64'h40000000, 9, "clmulh w32a4"});
    tablo.push_back('{1, ZBC_CLMULR, 64'h80000000, 64'h80000000, 64'h80000000, 9, "clmulr w32a4"});
    tablo.push_back('{1, ZBC_CLMUL,  64'h12345678, 64'h1, 64'h12345678, 9, "clmul x1 w32a4"});
    tablo.push_back('{0, ZBA_SH2ADD, 64'd3, 64'd10, 64'd22, 1, "sh2add"});
    tablo.push_back('{0, ZBS_BSET,   64'd0, 64'd37, 64'h20, 1, "bset idx wrap"});
    tablo.push_back('{0, ZBS_BEXT,   64'h80000000, 64'd31, 64'h1, 1, "bext msb"});
    tablo.push_back('{0, ZBA_SH1ADD, 64'd5, 64'd1, 64'd11, 1, "sh1add"});
    tablo.push_back('{0, ZBA_SH3ADD, 64'hFFFFFFFF, 64'd8, 64'h0, 1, "sh3add wrap"});
    tablo.push_back('{0, ZBS_BCLR,   64'hFFFFFFFF, 64'd0, 64'hFFFFFFFE, 1, "bclr bit0"});
    tablo.push_back('{0, ZBS_BINV,   64'h0F, 64'd3, 64'h07, 1, "binv"});
    tablo.push_back('{0, ZBS_BEXT,   64'h10, 64'd36, 64'h1, 1, "bext idx wrap"});
    tablo.push_back('{0, ISLEM_YOK,  64'h1234, 64'h5678, 64'h0, 1, "other op"});
    tablo.push_back('{2, ZBC_CLMUL,  64'hFFFFFFFFFFFFFFFF, 64'h3, 64'h1, 9, "clmul w64a8"});
    tablo.push_back('{2, ZBC_CLMULH, 64'hFFFFFFFFFFFFFFFF, 64'h3, 64'h1, 9, "clmulh w64a8"});
    tablo.push_back('{2, ZBA_SH1ADD, 64'h8000000000000000, 64'h1, 64'h1, 1, "sh1add w64"});
    tablo.push_back('{2, ZBS_BSET,   64'h0, 64'd37, 64'h2000000000, 1, "bset w64"});

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset hazir_o", {61'h0, hz}, 64'h7);
    chk("reset gecerli_o", {61'h0, gv}, 64'h0);
    chk("reset sonuc0", son(0), 64'h0);
    chk("reset sonuc2", son(2), 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < tablo.size(); i++) begin
      run_op(tablo[i].u, tablo[i].op, tablo[i].a, tablo[i].b, tablo[i].exp, tablo[i].lat,
             tablo[i].nm);
    end

    // Backpressure in SONUC: result held, no acceptance while stalled
    @(negedge clk);
    hazir_i = 1'b0;
    islem = ZBA_SH2ADD; v1 = 64'd3; v2 = 64'd10; vld[0] = 1'b1;
    @(posedge clk);
    #1;
    islem = ZBA_SH1ADD; v1 = 64'd1; v2 = 64'd1;
    chk("stall first valid", {63'h0, gv[0]}, 64'h1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("stall gecerli_o", {63'h0, gv[0]}, 64'h1);
      chk("stall sonuc_o", son(0), 64'd22);
      chk("stall hazir_o", {63'h0, hz[0]}, 64'h0);
    end
    @(negedge clk);
    hazir_i = 1'b1;
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    chk("stall release hazir_o", {63'h0, hz[0]}, 64'h1);
    chk("stall release gecerli_o", {63'h0, gv[0]}, 64'h0);
    @(posedge clk);
    #1;
    chk("stall request not taken", {63'h0, gv[0]}, 64'h0);

    // Flush at HESAPLA cycle 10
    @(negedge clk);
    islem = ZBC_CLMUL; v1 = 64'h3; v2 = 64'h3; vld[0] = 1'b1;
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    iptal = 1'b1;
    @(posedge clk);
    #1;
    iptal = 1'b0;
    chk("flush hazir_o", {63'h0, hz[0]}, 64'h1);
    chk("flush gecerli_o", {63'h0, gv[0]}, 64'h0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (gv[0] || s0 != 32'h0) cnt++;
    end
    chk("flush no result", 64'(cnt), 64'h0);
    run_op(0, ZBC_CLMUL, 64'h3, 64'h7, 64'h9, 33, "clmul after flush");

    // Reset while holding a result in SONUC
    @(negedge clk);
    hazir_i = 1'b0;
    islem = ZBS_BSET; v1 = 64'h0; v2 = 64'd4; vld[0] = 1'b1;
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    chk("sonuc hold before reset", son(0), 64'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("reset in SONUC gecerli_o", {63'h0, gv[0]}, 64'h0);
    chk("reset in SONUC sonuc_o", son(0), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    hazir_i = 1'b1;

    // Reset pulse mid-HESAPLA on the 64-bit instance
    @(negedge clk);
    islem = ZBC_CLMUL; v1 = '1; v2 = 64'h3; vld[2] = 1'b1;
    @(posedge clk);
    #1;
    vld[2] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset mid-hesapla hazir_o", {63'h0, hz[2]}, 64'h1);
    chk("reset mid-hesapla gecerli_o", {63'h0, gv[2]}, 64'h0);
    chk("reset mid-hesapla sonuc_o", son(2), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (gv[2]) cnt++;
    end
    chk("reset discards op", 64'(cnt), 64'h0);
    run_op(2, ZBC_CLMULH, 64'hFFFFFFFFFFFFFFFF, 64'h3, 64'h1, 9, "clmulh after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
